adc_spi_rx_multi: RTL and testbench

ADC_SPI_RX_MULTI -- requirements
Module: adc_spi_rx_multi

---
 rtl/adc_spi_rx_multi.sv | 149 ++++++++++++++
 tb/tb_adc_spi_rx_multi.sv | 228 ++++++++++++++++++++++
 2 files changed

// File: rtl/adc_spi_rx_multi.sv
// Multi-channel serial ADC frame receiver: shifts CS-low frames in on SCLK, formats
// the low RES bits, and stores each completed sample in a per-channel bank.
module adc_spi_rx_multi #(
  parameter int FRAME_BITS = 16,
  parameter int RES        = 12,
  parameter int LSH        = 2,
  parameter int OUT_W      = 16,
  parameter int NCH        = 4,
  parameter int TWOS       = 1,
  localparam int CH_W      = (NCH > 1) ? $clog2(NCH) : 1
) (
  input  logic                  SCLK,
  input  logic                  reset,
  input  logic                  CS,
  input  logic                  SDATA,
  input  logic                  ch_clr,
  input  logic [CH_W-1:0]       rd_ch,
  output logic [OUT_W-1:0]      rd_data,
  output logic [OUT_W-1:0]      data_out,
  output logic [CH_W-1:0]       ch_id,
  output logic                  rx_done_tick,
  output logic                  frame_err,
  output logic [FRAME_BITS-1:0] shift_reg
);

  localparam int CNT_W = $clog2(FRAME_BITS);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(FRAME_BITS - 2);
  localparam logic [CH_W-1:0]  CH_LAST  = CH_W'(NCH - 1);
  localparam logic [CH_W:0]    NCH_L    = (CH_W + 1)'(NCH);

  localparam logic [1:0] IDLE    = 2'd0;
  localparam logic [1:0] SHIFT   = 2'd1;
  localparam logic [1:0] WAIT_CS = 2'd2;

  logic [1:0]            state_r;
  logic [CNT_W-1:0]      cnt_r;
  logic [FRAME_BITS-1:0] shift_r;
  logic [CH_W-1:0]       ch_ptr_r;
  logic [CH_W-1:0]       ch_id_r;
  logic [OUT_W-1:0]      data_r;
  logic                  done_r;
  logic                  err_r;
  logic [OUT_W-1:0]      bank_r [NCH];
  logic [OUT_W-1:0]      fmt_s;
  logic                  frame_end_s;
  logic [CH_W-1:0]       ch_next_s;

  // Offset-binary becomes two's complement by flipping the field MSB and sign-extending.
  function automatic logic [OUT_W-1:0] fmt_sample(input logic [RES-1:0] field);
    logic [RES-1:0]   adj;
    logic [OUT_W-1:0] ext;
    adj = field;
    if (TWOS != 0) begin
      adj[RES-1] = ~adj[RES-1];
      ext = OUT_W'($signed(adj));
    end else begin
      ext = OUT_W'(adj);
    end
    return ext << LSH;
  endfunction

  assign fmt_s = fmt_sample(shift_r[RES-1:0]);

  // Channel pointer next value: clear wins over the per-frame advance.
  always_comb begin
    frame_end_s = (state_r == WAIT_CS) && CS;
    if (ch_clr) begin
      ch_next_s = {CH_W{1'b0}};
    end else if (frame_end_s) begin
      ch_next_s = (ch_ptr_r == CH_LAST) ? {CH_W{1'b0}} : ch_ptr_r + CH_W'(1);
    end else begin
      ch_next_s = ch_ptr_r;
    end
  end

  // Frame FSM, shift register, result registers and sample bank.
  always_ff @(posedge SCLK or posedge reset) begin
    if (reset) begin
      state_r  <= IDLE;
      cnt_r    <= {CNT_W{1'b0}};
      shift_r  <= {FRAME_BITS{1'b0}};
      ch_ptr_r <= {CH_W{1'b0}};
      ch_id_r  <= {CH_W{1'b0}};
      data_r   <= {OUT_W{1'b0}};
      done_r   <= 1'b0;
      err_r    <= 1'b0;
      for (int i = 0; i < NCH; i++) begin
        bank_r[i] <= {OUT_W{1'b0}};
      end
    end else begin
      done_r   <= 1'b0;
      err_r    <= 1'b0;
      ch_ptr_r <= ch_next_s;
      case (state_r)
        IDLE: begin
          if (!CS) begin
            shift_r <= {shift_r[FRAME_BITS-2:0], SDATA};
            cnt_r   <= {CNT_W{1'b0}};
            state_r <= SHIFT;
          end else begin
            state_r <= IDLE;
          end
        end
        SHIFT: begin
          if (!CS) begin
            shift_r <= {shift_r[FRAME_BITS-2:0], SDATA};
            if (cnt_r == CNT_LAST) begin
              state_r <= WAIT_CS;
            end else begin
              cnt_r <= cnt_r + CNT_W'(1);
            end
          end else begin
            // CS rose before the frame was complete: drop it and flag the abort.
            err_r   <= 1'b1;
            state_r <= IDLE;
          end
        end
        WAIT_CS: begin
          if (CS) begin
            data_r           <= fmt_s;
            ch_id_r          <= ch_ptr_r;
            bank_r[ch_ptr_r] <= fmt_s;
            done_r           <= 1'b1;
            state_r          <= IDLE;
          end else begin
            state_r <= WAIT_CS;
          end
        end
        default: state_r <= IDLE;
      endcase
    end
  end

  // Bank read port; addresses beyond the populated channels read as zero.
  always_comb begin
    if ({1'b0, rd_ch} < NCH_L) begin
      rd_data = bank_r[rd_ch];
    end else begin
      rd_data = {OUT_W{1'b0}};
    end
  end

  assign data_out     = data_r;
  assign ch_id        = ch_id_r;
  assign rx_done_tick = done_r;
  assign frame_err    = err_r;
  assign shift_reg    = shift_r;

endmodule

// File: tb/tb_adc_spi_rx_multi.sv
// Bench for adc_spi_rx_multi: a TWOS=1 and a TWOS=0 instance share stimulus and are
// compared every cycle against a frame-level model, plus literal pins.
module tb_adc_spi_rx_multi;
  localparam int FB = 16, RES = 12, LSH = 2, OW = 16, NCH = 4, CW = 2;

  logic SCLK = 1'b0;
  logic reset = 1'b0, CS = 1'b1, SDATA = 1'b0, ch_clr = 1'b0;
  logic [CW-1:0] rd_ch = '0;
  logic [OW-1:0] rd_a, rd_b, do_a, do_b;
  logic [CW-1:0] ch_a, ch_b;
  logic done_a, done_b, err_a, err_b;
  logic [FB-1:0] sh_a, sh_b;

  adc_spi_rx_multi dut_a (
    .SCLK(SCLK), .reset(reset), .CS(CS), .SDATA(SDATA), .ch_clr(ch_clr), .rd_ch(rd_ch),
    .rd_data(rd_a), .data_out(do_a), .ch_id(ch_a), .rx_done_tick(done_a),
    .frame_err(err_a), .shift_reg(sh_a));

  adc_spi_rx_multi #(.TWOS(0)) dut_b (
    .SCLK(SCLK), .reset(reset), .CS(CS), .SDATA(SDATA), .ch_clr(ch_clr), .rd_ch(rd_ch),
    .rd_data(rd_b), .data_out(do_b), .ch_id(ch_b), .rx_done_tick(done_b),
    .frame_err(err_b), .shift_reg(sh_b));

  always #5 SCLK = ~SCLK;

  int checks = 0, failures = 0, done_cnt = 0, err_cnt = 0;
  bit cmp_en = 1'b0;

  // Frame-level model: bits collected since CS fell, channel pointer, per-instance results.
  logic [FB-1:0] m_shift;
  int            m_bits, m_ptr;
  logic [OW-1:0] m_data [2];
  logic [CW-1:0] m_ch;
  logic          m_done, m_err;
  logic [OW-1:0] m_bank [2][NCH];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [OW-1:0] fmt_model(input logic [FB-1:0] raw, input int twos);
    int v;
    logic [31:0] r;
    v = int'(raw) % (1 << RES);
    if (twos != 0) v = v - (1 << (RES - 1));
    r = v * (1 << LSH);
    return r[OW-1:0];
  endfunction

  function automatic void model_reset();
    m_shift = '0; m_bits = 0; m_ptr = 0; m_ch = '0; m_done = 1'b0; m_err = 1'b0;
    for (int k = 0; k < 2; k++) begin
      m_data[k] = '0;
      for (int c = 0; c < NCH; c++) m_bank[k][c] = '0;
    end
  endfunction

  function automatic void model_edge(input logic cs, input logic sd, input logic clr);
    m_done = 1'b0;
    m_err  = 1'b0;
    if (!cs) begin
      if (m_bits < FB) begin
        m_shift = {m_shift[FB-2:0], sd};
        m_bits++;
      end
    end else begin
      if (m_bits == FB) begin
        m_data[0] = fmt_model(m_shift, 1);
        m_data[1] = fmt_model(m_shift, 0);
        m_bank[0][m_ptr] = m_data[0];
        m_bank[1][m_ptr] = m_data[1];
        m_ch   = CW'(m_ptr);
        m_done = 1'b1;
        m_ptr  = (m_ptr + 1) % NCH;
      end else if (m_bits > 0) begin
        m_err = 1'b1;
      end
      m_bits = 0;
    end
    if (clr) m_ptr = 0;
  endfunction

  // Per-cycle comparison of both instances against the model.
  always @(posedge SCLK) begin
    #1;
    if (cmp_en) begin
      chk("data_out_a", 32'(do_a), 32'(m_data[0]));
      chk("data_out_b", 32'(do_b), 32'(m_data[1]));
      chk("ch_id_a", 32'(ch_a), 32'(m_ch));
      chk("ch_id_b", 32'(ch_b), 32'(m_ch));
      chk("done_a", 32'(done_a), 32'(m_done));
      chk("done_b", 32'(done_b), 32'(m_done));
      chk("err_a", 32'(err_a), 32'(m_err));
      chk("err_b", 32'(err_b), 32'(m_err));
      chk("shift_a", 32'(sh_a), 32'(m_shift));
      chk("shift_b", 32'(sh_b), 32'(m_shift));
      chk("rd_data_a", 32'(rd_a), 32'(m_bank[0][rd_ch]));
      chk("rd_data_b", 32'(rd_b), 32'(m_bank[1][rd_ch]));
      if (done_a) done_cnt++;
      if (err_a) err_cnt++;
    end
  end

  task automatic step(input logic cs, input logic sd, input logic clr);
    @(negedge SCLK);
    CS = cs; SDATA = sd; ch_clr = clr;
    model_edge(cs, sd, clr);
  endtask

  task automatic send_bits(input logic [31:0] v, input int n);
    for (int i = 0; i < n; i++) step(1'b0, v[FB-1-i], 1'b0);
  endtask

  task automatic send_frame(input logic [31:0] v, input int clr_bit, input int extra);
    for (int i = FB - 1; i >= 0; i--) step(1'b0, v[i], (i == clr_bit));
    for (int j = 0; j < extra; j++) step(1'b0, 1'b1, 1'b0);
    step(1'b1, 1'b0, 1'b0);
    step(1'b1, 1'b0, 1'b0);
  endtask

  task automatic reset_pulse();
    @(negedge SCLK);
    reset = 1'b1; CS = 1'b1; ch_clr = 1'b0;
    model_reset();
    repeat (2) @(negedge SCLK);
    reset = 1'b0;
  endtask

  task automatic check_zero(input string tag);
    chk({tag, "_data_out"}, 32'(do_a), 32'h0);
    chk({tag, "_ch_id"}, 32'(ch_a), 32'h0);
    chk({tag, "_shift"}, 32'(sh_a), 32'h0);
    for (int r = 0; r < NCH; r++) begin
      rd_ch = CW'(r);
      #1;
      chk({tag, "_bank"}, 32'(rd_a), 32'h0);
    end
    rd_ch = '0;
  endtask

  logic [15:0] five [5] = '{16'h0123, 16'h0456, 16'h0789, 16'h0ABC, 16'h0DEF};
  int d0, e0;

  initial begin
    #2;
    reset = 1'b1;
    model_reset();
    cmp_en = 1'b1;
    repeat (2) @(negedge SCLK);
    check_zero("reset");
    @(negedge SCLK);
    reset = 1'b0;

    // Full-scale positive code.
    send_frame(32'h0FFF, -1, 0);
    chk("pin_1ffc", 32'(do_a), 32'h1FFC);
    chk("pin_model_1ffc", 32'(m_data[0]), 32'h1FFC);
    chk("pin_ch0", 32'(ch_a), 32'h0);
    chk("pin_done_once", 32'(done_cnt), 32'd1);
    chk("pin_no_err", 32'(err_cnt), 32'd0);

    // Mid-scale and zero codes on consecutive channels.
    reset_pulse();
    send_frame(32'h0800, -1, 0);
    chk("pin_mid_a", 32'(do_a), 32'h0000);
    chk("pin_mid_b", 32'(do_b), 32'h2000);
    chk("pin_mid_ch", 32'(ch_a), 32'h0);
    send_frame(32'h0000, -1, 0);
    chk("pin_zero_a", 32'(do_a), 32'hE000);
    chk("pin_zero_b", 32'(do_b), 32'h0000);
    chk("pin_zero_ch", 32'(ch_a), 32'h1);
    rd_ch = 2'd1;
    #1;
    chk("pin_rd_ch1", 32'(rd_a), 32'hE000);
    send_frame(32'h0ABC, -1, 0);
    chk("pin_abc_b", 32'(do_b), 32'h2AF0);
    chk("pin_abc_a", 32'(do_a), 32'h0AF0);

    // Channel wrap over five frames.
    reset_pulse();
    for (int i = 0; i < 5; i++) begin
      send_frame(32'(five[i]), -1, 0);
      chk("pin_wrap_ch", 32'(ch_a), 32'(i % NCH));
    end
    rd_ch = 2'd0;
    #1;
    chk("pin_bank0_a", 32'(rd_a), 32'h17BC);
    chk("pin_bank0_b", 32'(rd_b), 32'h37BC);

    // Early CS rise after 9 bits, then a normal frame on the same channel.
    d0 = done_cnt; e0 = err_cnt;
    send_bits(32'h0000FFFF, 9);
    step(1'b1, 1'b0, 1'b0);
    step(1'b1, 1'b0, 1'b0);
    chk("pin_abort_err", 32'(err_cnt), 32'(e0 + 1));
    chk("pin_abort_nodone", 32'(done_cnt), 32'(d0));
    chk("pin_abort_data", 32'(do_a), 32'h17BC);
    chk("pin_abort_ch", 32'(ch_a), 32'h0);
    send_frame(32'h0FFF, -1, 0);
    chk("pin_after_abort_ch", 32'(ch_a), 32'h1);
    chk("pin_after_abort_data", 32'(do_a), 32'h1FFC);

    // Extra SCLKs while waiting for CS must not disturb the sample.
    send_frame(32'h0000, -1, 3);
    chk("pin_extra_data", 32'(do_a), 32'hE000);
    chk("pin_extra_ch", 32'(ch_a), 32'h2);

    // Reset mid-frame, then channel clear during a frame.
    send_bits(32'h0000FFFF, 7);
    reset_pulse();
    check_zero("midreset");
    send_frame(32'h0FFF, -1, 0);
    chk("pin_post_reset_ch", 32'(ch_a), 32'h0);
    send_frame(32'h0800, 5, 0);
    chk("pin_clr_ch", 32'(ch_a), 32'h0);
    chk("pin_clr_data", 32'(do_a), 32'h0000);
    send_frame(32'h0FFF, -1, 0);
    chk("pin_clr_next_ch", 32'(ch_a), 32'h1);

    repeat (3) @(negedge SCLK);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
